// File: rtl/cmd_issuer.sv
// cmd_issuer: serialises header + buffered payload words onto the
// controller instruct bus, with a small payload FIFO in front.
module cmd_issuer #(
    parameter int DEPTH = 8,
    parameter int HOLD  = 1
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        wr_valid,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    input  logic        req_valid,
    input  logic [3:0]  req_opcode,
    input  logic [4:0]  req_len,
    output logic        req_ready,
    output logic [31:0] instruct,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH5 = 5'(DEPTH);
    localparam logic [3:0] RELOAD = 4'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        GAP
    } state_t;

    state_t state, state_n;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr, rnext;
    logic [AW:0]   count;
    logic [4:0]    cnt5;
    logic [3:0]    hcnt, hcnt_n;
    logic [4:0]    len, len_n;
    logic [31:0]   instruct_n;
    logic          busy_n, done_n, err_n;
    logic          bad, push, pop;

    assign cnt5      = 5'(count);
    assign bad       = (req_len > DEPTH5);
    assign wr_ready  = (cnt5 < DEPTH5);
    assign req_ready = rst_n && (state == IDLE) &&
                       ((cnt5 >= req_len) || bad);
    assign push      = wr_valid && wr_ready;
    assign pop       = (state == PAYLOAD) && (hcnt == 4'd0);
    assign rnext     = rptr + 1'b1;

    always_comb begin
        state_n    = state;
        hcnt_n     = hcnt;
        len_n      = len;
        instruct_n = instruct;
        busy_n     = busy;
        done_n     = 1'b0;
        err_n      = 1'b0;
        unique case (state)
            IDLE: begin
                instruct_n = 32'h0;
                busy_n     = 1'b0;
                if (req_valid && req_ready) begin
                    if (bad) begin
                        err_n = 1'b1;
                    end else begin
                        state_n    = HEADER;
                        len_n      = req_len;
                        hcnt_n     = RELOAD;
                        instruct_n = {1'b1, 27'b0, req_opcode};
                        busy_n     = 1'b1;
                    end
                end
            end
            HEADER: begin
                if (hcnt != 4'd0) begin
                    hcnt_n = hcnt - 4'd1;
                end else if (len != 5'd0) begin
                    state_n    = PAYLOAD;
                    hcnt_n     = RELOAD;
                    instruct_n = mem[rptr];
                end else begin
                    state_n    = GAP;
                    instruct_n = 32'h0;
                    done_n     = 1'b1;
                end
            end
            PAYLOAD: begin
                if (hcnt != 4'd0) begin
                    hcnt_n = hcnt - 4'd1;
                end else begin
                    len_n = len - 5'd1;
                    if (len == 5'd1) begin
                        state_n    = GAP;
                        instruct_n = 32'h0;
                        done_n     = 1'b1;
                    end else begin
                        hcnt_n     = RELOAD;
                        instruct_n = mem[rnext];
                    end
                end
            end
            GAP: begin
                state_n    = IDLE;
                instruct_n = 32'h0;
                busy_n     = 1'b0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hcnt     <= 4'd0;
            len      <= 5'd0;
            instruct <= 32'h0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            hcnt     <= hcnt_n;
            len      <= len_n;
            instruct <= instruct_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rnext;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= wr_data;
    end

endmodule
